// File: rtl/booth_mac_acc.sv
// Signed multiply-accumulate stage: sums framed 16-bit product terms into an ACC_W-bit
// accumulator and presents the registered frame result over a valid/ready handshake.
module booth_mac_acc #(
   parameter int ACC_W = 24,
   parameter bit SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_p,
   input  logic             in_first,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic [7:0]       out_cnt,
   output logic [1:0]       dbg_state
);

   // Handshake: a beat happens on a rising edge where valid & ready are both high.
   // in_ready depends on state only; out_valid is a register, high exactly in HOLD.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t           state;
   state_t           state_nx;
   logic [ACC_W-1:0] acc;
   logic [7:0]       cnt;
   logic             ovf;

   logic             in_beat;
   logic             out_beat;
   logic             start;
   logic [ACC_W-1:0] term;
   logic [ACC_W-1:0] base;
   logic [ACC_W:0]   sum;
   logic             ovf_term;
   logic [ACC_W-1:0] res;
   logic [7:0]       cnt_nx;
   logic             ovf_nx;

   assign in_ready  = (state != HOLD);
   assign in_beat   = in_valid & in_ready;
   assign out_beat  = out_valid & out_ready;
   assign dbg_state = state;

   always_comb begin
      start    = in_first | (state == IDLE);
      term     = {{(ACC_W-16){in_p[15]}}, in_p};
      base     = start ? '0 : acc;
      sum      = {base[ACC_W-1], base} + {term[ACC_W-1], term};
      ovf_term = sum[ACC_W] ^ sum[ACC_W-1];
      res      = sum[ACC_W-1:0];
      if (SAT && ovf_term) begin
         // The extra top bit carries the true sign of the unclamped sum.
         res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
      ovf_nx = ovf_term | (start ? 1'b0 : ovf);
      if (start) begin
         cnt_nx = 8'd1;
      end else if (cnt == 8'd255) begin
         cnt_nx = cnt;
      end else begin
         cnt_nx = cnt + 8'd1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, ACCUM: begin
            if (in_beat) begin
               state_nx = in_last ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (out_beat) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_acc   <= '0;
         out_cnt   <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (in_beat) begin
            acc <= res;
            cnt <= cnt_nx;
            ovf <= ovf_nx;
            if (in_last) begin
               out_acc   <= res;
               out_cnt   <= cnt_nx;
               out_ovf   <= ovf_nx;
               out_valid <= 1'b1;
            end
         end else if (out_beat) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
